// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_arbiter_pkg;

  localparam int DW = 32;
  localparam logic [DW-1:0] ERR_WORD_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    MEM_I,
    MEM_D,
    RESP
  } arb_state_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - loadable down-counter flagging when the memory wait budget is spent
module arb_timeout_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int              TIMEOUT    = 16,
  parameter int              STARVE_MAX = 4,
  parameter logic [DW-1:0]   ERR_WORD   = ERR_WORD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [DW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [DW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [DW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          cpu_stall,
  output logic          bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          m_req_q, m_req_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          bus_err_q, bus_err_d;
  logic          tmo_load, tmo_dec, tmo_expired;
  logic          fetch_wins;
  logic [DW-1:0] resp_word;

  arb_timeout_cnt #(.W(TW)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (TW'(TIMEOUT - 1)),
    .dec      (tmo_dec),
    .expired  (tmo_expired)
  );

  // Data normally wins; a fetch that has watched STARVE_MAX data grants goes next.
  assign fetch_wins = i_req && (!d_req || (starve_q == SW'(STARVE_MAX)));
  assign resp_word  = m_ready ? m_rdata : ERR_WORD;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    m_req_d   = m_req_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    bus_err_d = 1'b0;
    tmo_load  = 1'b0;
    tmo_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          m_req_d  = 1'b1;
          tmo_load = 1'b1;
          if (fetch_wins) begin
            state_d  = MEM_I;
            addr_d   = i_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            state_d = MEM_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            if (i_req && (starve_q != SW'(STARVE_MAX))) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      MEM_I, MEM_D: begin
        if (m_ready || tmo_expired) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          bus_err_d = !m_ready;
          if (state_q == MEM_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_word;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = resp_word;
            end
          end
        end else begin
          tmo_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      m_req_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      m_req_q   <= m_req_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign cpu_stall = (i_req && !i_ack_q) || (d_req && !d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready, cpu_stall, bus_err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .cpu_stall(cpu_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_errs = 0;
  int          ack_cnt = 0;
  logic [31:0] mem [logic [31:0]];
  int          mem_wait = 0;
  bit          mem_hang = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] i_model = '0;
  logic [31:0] d_model = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  task automatic push(input logic is_d, input logic [31:0] rdata, input logic err);
    exp_t x;
    x.is_d = is_d; x.rdata = rdata; x.err = err;
    sb.push_back(x);
    if (is_d) d_model = rdata; else i_model = rdata;
  endtask

  // Memory: answers after mem_wait cycles of m_req, or never while mem_hang.
  always @(negedge clk) begin
    if (reset || !m_req) begin
      m_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (!mem_hang && wcnt >= mem_wait) begin
        m_ready = 1'b1;
        m_rdata = rd(m_addr);
        if (m_we) begin
          mem[m_addr] = m_wdata;
          wr_cnt++;
          wr_addr = m_addr;
          wr_data = m_wdata;
        end
      end else begin
        m_ready = 1'b0;
      end
      wcnt++;
    end
  end

  always @(negedge clk) begin
    if (!reset && (i_ack || d_ack)) begin
      ack_cnt++;
      check("single_ack", 32'(i_ack & d_ack), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port", 32'(d_ack), 32'(e.is_d));
        check(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        check("bus_err", 32'(bus_err), 32'(e.err));
      end
    end
  end

  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    bit got;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    lat = 0;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      lat++;
      got = is_d ? d_ack : i_ack;
    end
    if (!got) check("ack_wait", 32'd0, 32'd1);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic serve_pair();
    for (int n = 0; n < 40 && (i_req || d_req); n++) begin
      @(negedge clk);
      if (i_ack) i_req = 1'b0;
      if (d_ack) d_req = 1'b0;
    end
    check("pair_done", 32'(i_req | d_req), 32'd0);
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    int  lat;
    int  acks_before;
    bit  got_i;
    reset = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_ready = 0; m_rdata = '0;
    mem[32'h0]  = 32'h20020005;
    mem[32'h4]  = 32'h00001004;
    mem[32'h8]  = 32'hA5A50008;
    mem[32'h40] = 32'h12344321;
    repeat (3) @(negedge clk);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;

    // Single zero-wait fetch: stall in cycles 1-2, ack in cycle 3.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0;
    push(0, 32'h20020005, 0);
    @(negedge clk);
    check("fetch_c1_stall", 32'(cpu_stall), 32'd1);
    check("fetch_c1_ack", 32'(i_ack), 32'd0);
    @(negedge clk);
    check("fetch_c2_stall", 32'(cpu_stall), 32'd1);
    check("fetch_c2_mreq", 32'(m_req), 32'd1);
    check("fetch_c2_mwe", 32'(m_we), 32'd0);
    check("fetch_c2_maddr", m_addr, 32'h0);
    @(negedge clk);
    check("fetch_c3_ack", 32'(i_ack), 32'd1);
    check("fetch_c3_stall", 32'(cpu_stall), 32'd0);
    i_req = 1'b0;

    // Fetch with two wait states.
    mem_wait = 2;
    push(0, 32'h00001004, 0);
    access(0, 0, 32'h4, 32'h0, lat);
    check("wait2_latency", 32'(lat), 32'd5);
    mem_wait = 0;

    // Conflict: data first, then fetch.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    push(1, 32'h12344321, 0);
    push(0, 32'hA5A50008, 0);
    serve_pair();

    // Starvation: four data grants, then the fetch.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) push(1, 32'h12344321, 0);
    push(0, 32'h20020005, 0);
    got_i = 0;
    for (int n = 0; n < 60 && !got_i; n++) begin
      @(negedge clk);
      if (i_ack) begin
        i_req = 1'b0; d_req = 1'b0; got_i = 1;
      end
    end
    check("starve_fetch_seen", 32'(got_i), 32'd1);

    // Starve count cleared: a fresh conflict goes to data again.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_addr = 32'h40;
    push(1, 32'h12344321, 0);
    push(0, 32'h00001004, 0);
    serve_pair();
    check("no_fetch_writes", 32'(wr_cnt), 32'd0);

    // Timeout: 16 wait cycles then error response.
    mem_hang = 1;
    push(1, 32'hDEADBEEF, 1);
    access(1, 0, 32'h80, 32'h0, lat);
    check("timeout_latency", 32'(lat), 32'd18);
    mem_hang = 0;

    // Store leaves d_rdata as it was.
    push(1, d_model, 0);
    access(1, 1, 32'h54, 32'h7, lat);
    check("store_cnt", 32'(wr_cnt), 32'd1);
    check("store_addr", wr_addr, 32'h54);
    check("store_data", wr_data, 32'h7);
    check("i_rdata_hold", i_rdata, i_model);

    // Reset mid-access: m_req drops without a clock edge; no ack for it.
    @(posedge clk); #1;
    mem_hang = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    @(negedge clk);
    @(negedge clk);
    check("mid_mreq", 32'(m_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_mreq", 32'(m_req), 32'd0);
    check("rst_async_drdata", d_rdata, 32'd0);
    check("rst_async_irdata", i_rdata, 32'd0);
    d_req = 1'b0;
    mem_hang = 0;
    acks_before = ack_cnt;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0;
    push(0, 32'h20020005, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_c1_ack", 32'(i_ack), 32'd0);
    @(negedge clk);
    check("post_rst_c2_ack", 32'(i_ack), 32'd1);
    i_req = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_ack_cnt", 32'(ack_cnt - acks_before), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of memory cycles waited for m_ready before a bus error is signalled.
REQ-002 Parameter STARVE_MAX, default 4, is the number of consecutive data grants allowed while a fetch is pending.
REQ-003 Parameter ERR_WORD, default 32'hDEADBEEF, is the read data returned on timeout.
REQ-004 The block SHALL have exactly one clock and an asynchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
REQ-005 The block SHALL provide the instruction-fetch port:
- i_req  in  1  fetch request.
- i_addr  in  32  fetch byte address (the pc).
- i_rdata  out  32  fetched instr.
- i_ack  out  1  fetch done, 1-cycle pulse.
REQ-006 The block SHALL provide the data port:
- d_req  in  1  load/store request.
- d_we  in  1  1 = store (memwrite).
- d_addr  in  32  aluout.
- d_wdata  in  32  writedata.
- d_rdata  out  32  readdata.
- d_ack  out  1  done, 1-cycle pulse.
REQ-007 The block SHALL provide the memory port and status outputs:
- m_req  out  1  memory access request.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data.
- m_ready  in  1  access complete.
- cpu_stall  out  1  CPU must hold state.
- bus_err  out  1  timeout pulse.

Function
REQ-008 The FSM SHALL have states IDLE, MEM_I, MEM_D and RESP.
REQ-009 In IDLE with any request pending, the FSM SHALL go to MEM_I or MEM_D next cycle, latching address, we and wdata from the winner.
REQ-010 Arbitration SHALL use fixed data-over-fetch priority, except that the fetch SHALL win when i_req is pending and starve_cnt == STARVE_MAX.
REQ-011 starve_cnt SHALL increment on each data grant made while i_req is high, saturate at STARVE_MAX, and clear on any fetch grant.
REQ-012 In MEM_x, m_req SHALL be 1 and m_addr/m_we/m_wdata SHALL be stable; m_we SHALL be 0 for fetches.
REQ-013 m_ready sampled high in MEM_x SHALL move the FSM to RESP and register m_rdata into the winner's rdata register.
REQ-014 RESP SHALL pulse the winner's ack for exactly 1 cycle, then return to IDLE.
REQ-015 Minimum latency SHALL be 3 cycles from req to ack with a zero-wait memory; throughput is one access per 3 cycles.
REQ-016 If m_ready has not arrived after TIMEOUT cycles in MEM_x, the FSM SHALL go to RESP with rdata = ERR_WORD and bus_err pulsed alongside the ack.
REQ-017 i_rdata and d_rdata SHALL hold their value until that port's next ack.
REQ-018 A requester dropping req mid-access SHALL NOT abort the access; the ack SHALL still pulse.
REQ-019 A store SHALL leave d_rdata unchanged.
REQ-020 cpu_stall SHALL equal (i_req & ~i_ack) | (d_req & ~d_ack) and be combinational.
REQ-021 Simultaneous i_req and d_req in IDLE SHALL grant exactly one requester, per REQ-010.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE and zero all outputs, rdata registers, starve_cnt and the timeout counter; m_req SHALL drop with no clock edge required, including mid-access.
REQ-023 After reset deasserts, the first arbitration SHALL occur on the next rising edge.

Structure
REQ-024 A shared package SHALL hold the state enum, the ERR_WORD default, and the address/data width constant (32).
REQ-025 A single sub-module, arb_timeout_cnt (loadable down-counter with an expire flag), is natural; all else SHALL be in mem_arbiter.

Verification
REQ-026 Single fetch: i_addr=0, m_rdata=32'h20020005, zero-wait -> i_ack in cycle 3, i_rdata=32'h20020005, cpu_stall high in cycles 1-2.
REQ-027 Conflict: i_req and d_req (load 0x40) in the same cycle -> data served first, then fetch; d_rdata=32'h12344321.
REQ-028 Starvation: d_req held high with i_req high -> the 5th grant goes to the fetch; starve_cnt returns to 0.
REQ-029 Timeout: m_ready held low -> RESP after 16 wait cycles, bus_err=1, d_rdata=32'hDEADBEEF.
REQ-030 Store: d_we=1, d_addr=0x54, d_wdata=7 -> m_we=1, m_addr=0x54, m_wdata=7; d_rdata unchanged.
REQ-031 Reset mid-access: reset asserted in MEM_D with m_ready low -> m_req=0 within the same cycle; no ack ever pulses for that access.
